// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard control slice.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W      = 5;
    localparam int unsigned MEM_TIMEOUT_DEF = 255;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifid_flush;
        logic idex_bubble;
    } ctrl_t;

    function automatic ctrl_t ctrl_make(
        input logic front_we,
        input logic back_we,
        input logic flush,
        input logic bubble
    );
        ctrl_t c;
        c.pc_we       = front_we;
        c.ifid_we     = front_we;
        c.idex_we     = back_we;
        c.exmem_we    = back_we;
        c.memwb_we    = back_we;
        c.ifid_flush  = flush;
        c.idex_bubble = bubble;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the ID sources and a load sitting in EX.
module hazard_detect
    import pipeline_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_wr_reg_i,
    input  logic                  ex_mem_read_i,
    output logic                  load_use_o
);

    logic rs1_hit;
    logic rs2_hit;
    logic wr_valid;

    assign rs1_hit  = id_use_rs1_i && (id_rs1_i == ex_wr_reg_i);
    assign rs2_hit  = id_use_rs2_i && (id_rs2_i == ex_wr_reg_i);
    // x0 is never a real destination
    assign wr_valid = ex_wr_reg_i != '0;

    assign load_use_o = ex_mem_read_i && wr_valid && (rs1_hit || rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush control: memory-wait FSM, load-use stall, branch flush,
// stall statistics and a sticky memory timeout flag.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_use_rs1_i,
    input  logic                  id_use_rs2_i,
    input  logic [REG_ADDR_W-1:0] ex_wr_reg_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_branch_taken_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ready_i,
    output logic                  pc_we_o,
    output logic                  ifid_we_o,
    output logic                  idex_we_o,
    output logic                  exmem_we_o,
    output logic                  memwb_we_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic                  mem_err_o
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    state_e               state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 mem_err_q, mem_err_d;

    logic  load_use;
    logic  mem_stall;
    logic  m_rst, m_mem, m_flush, m_lu, m_norm;
    ctrl_t ctrl;

    hazard_detect u_detect (
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_use_rs1_i  (id_use_rs1_i),
        .id_use_rs2_i  (id_use_rs2_i),
        .ex_wr_reg_i   (ex_wr_reg_i),
        .ex_mem_read_i (ex_mem_read_i),
        .load_use_o    (load_use)
    );

    assign mem_stall = (state_q == ST_MEM_WAIT) || (mem_req_i && !mem_ready_i);

    assign m_rst   = !rst_n;
    assign m_mem   = rst_n && mem_stall;
    assign m_flush = rst_n && !mem_stall && ex_branch_taken_i;
    assign m_lu    = rst_n && !mem_stall && !ex_branch_taken_i && load_use;
    assign m_norm  = rst_n && !mem_stall && !ex_branch_taken_i && !load_use;

    // A taken branch also squashes any load-use stall in the same cycle
    always_comb begin
        ctrl = '0;
        unique case (1'b1)
            m_rst:   ctrl = ctrl_make(1'b0, 1'b0, 1'b0, 1'b0);
            m_mem:   ctrl = ctrl_make(1'b0, 1'b0, 1'b0, 1'b0);
            m_flush: ctrl = ctrl_make(1'b1, 1'b1, 1'b1, 1'b1);
            m_lu:    ctrl = ctrl_make(1'b0, 1'b1, 1'b0, 1'b1);
            m_norm:  ctrl = ctrl_make(1'b1, 1'b1, 1'b0, 1'b0);
            default: ctrl = '0;
        endcase
    end

    assign pc_we_o       = ctrl.pc_we;
    assign ifid_we_o     = ctrl.ifid_we;
    assign idex_we_o     = ctrl.idex_we;
    assign exmem_we_o    = ctrl.exmem_we;
    assign memwb_we_o    = ctrl.memwb_we;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_bubble_o = ctrl.idex_bubble;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_req_i && !mem_ready_i) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                if (wait_cnt_d == WAIT_MAX) begin
                    mem_err_d = 1'b1;
                end
                if (mem_ready_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
        if ((m_mem || m_lu) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign mem_err_o   = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed corner cases plus random traffic
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    rs1 = '0, rs2 = '0, wr = '0;
    logic          u1 = 0, u2 = 0, mr = 0, bt = 0, req = 0, rdy = 0;
    logic          pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic          flush, bubble, mem_err;
    logic [CW-1:0] scnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_rs1_i          (rs1),
        .id_rs2_i          (rs2),
        .id_use_rs1_i      (u1),
        .id_use_rs2_i      (u2),
        .ex_wr_reg_i       (wr),
        .ex_mem_read_i     (mr),
        .ex_branch_taken_i (bt),
        .mem_req_i         (req),
        .mem_ready_i       (rdy),
        .pc_we_o           (pc_we),
        .ifid_we_o         (ifid_we),
        .idex_we_o         (idex_we),
        .exmem_we_o        (exmem_we),
        .memwb_we_o        (memwb_we),
        .ifid_flush_o      (flush),
        .idex_bubble_o     (bubble),
        .stall_cnt_o       (scnt),
        .mem_err_o         (mem_err)
    );

    typedef struct {
        logic [6:0] ctl;
        int         cnt;
        logic       err;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n = 0;

    bit   m_wait = 0;
    int   m_waited = 0;
    bit   m_err = 0;
    int   m_stalls = 0;

    task automatic step(input bit r, input logic [4:0] a, input logic [4:0] b,
                        input bit ua, input bit ub, input logic [4:0] w,
                        input bit ld, input bit br, input bit rq, input bit rd);
        exp_t e;
        bit   lu, ms;
        @(posedge clk);
        #1;
        rst_n = !r;
        rs1 = a; rs2 = b; u1 = ua; u2 = ub; wr = w;
        mr = ld; bt = br; req = rq; rdy = rd;
        cyc_n++;
        e.cyc = cyc_n;
        if (r) begin
            m_wait = 0; m_waited = 0; m_err = 0; m_stalls = 0;
            e.ctl = '0; e.cnt = 0; e.err = 0;
            q.push_back(e);
            return;
        end
        e.cnt = m_stalls;
        e.err = m_err;
        lu = ld && (w != 0) && ((ua && a == w) || (ub && b == w));
        ms = m_wait || (rq && !rd);
        // bit order: pc ifid idex exmem memwb flush bubble
        if (ms)      e.ctl = 7'b0000000;
        else if (br) e.ctl = 7'b1111111;
        else if (lu) e.ctl = 7'b0011101;
        else         e.ctl = 7'b1111100;
        q.push_back(e);
        if ((ms || (lu && !br)) && m_stalls < SAT) m_stalls++;
        if (m_wait) begin
            m_waited++;
            if (m_waited >= TO) m_err = 1;
            if (rd) m_wait = 0;
        end else if (rq && !rd) begin
            m_wait = 1;
            m_waited = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    exp_t       me;
    logic [6:0] act;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me  = q.pop_front();
            act = {pc_we, ifid_we, idex_we, exmem_we, memwb_we, flush, bubble};
            checks++;
            if (act !== me.ctl) begin
                errors++;
                $display("FAIL ctl cyc=%0d actual=%b required=%b", me.cyc, act, me.ctl);
            end
            checks++;
            if (int'(scnt) != me.cnt) begin
                errors++;
                $display("FAIL stall_cnt cyc=%0d actual=%0d required=%0d", me.cyc, scnt, me.cnt);
            end
            checks++;
            if (mem_err !== me.err) begin
                errors++;
                $display("FAIL mem_err cyc=%0d actual=%b required=%b", me.cyc, mem_err, me.err);
            end
        end
    end

    initial begin
        do_reset(2);
        idle(2);
        // load-use on rs1 == x5, then the bubble reaches EX
        step(0, 5, 0, 1, 0, 5, 1, 0, 0, 0);
        idle(2);
        // load to x0 never stalls
        step(0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        // load-use via rs2, unused-source match ignored
        step(0, 3, 7, 0, 1, 7, 1, 0, 0, 0);
        step(0, 7, 2, 0, 1, 7, 1, 0, 0, 0);
        // load-use with taken branch: flush wins
        step(0, 5, 0, 1, 0, 5, 1, 1, 0, 0);
        idle(1);
        // memory wait 3 cycles with a branch pending, then ready
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2);
        // timeout: ready never comes, reset pulse mid-wait
        do_reset(1);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        // saturation of the 4-bit stall counter
        for (int i = 0; i < 10; i++) step(0, 9, 0, 1, 0, 9, 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2);
        do_reset(1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                step(0,
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     5'($urandom_range(0, 3)),
                     $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d pending required=0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
